// File: rtl/keypad_matrix_scanner_if.sv
// Key-event handshake between keypad_matrix_scanner (master) and the
// mode/control decoder that consumes events (slave).
interface keypad_matrix_scanner_if #(
  parameter int KW = 4
);
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic          evt_release;

  modport master (output evt_valid, evt_key, evt_release, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_release, output evt_ready);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// R x C keypad scanner: frame-based debounce, FWFT event FIFO, sticky overflow.
// Define KEYPAD_RELEASE_EVT_EN to also queue release events.
module keypad_matrix_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE          = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COLS-1:0]         col,
  output logic [ROWS-1:0]         row,
  keypad_matrix_scanner_if.master evt,
  output logic                    key_held,
  output logic                    overflow,
  input  logic                    overflow_clr
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = RW + CW;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- scanner ----------------
  logic [SW-1:0] settle_q, settle_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic          sample, frame_end;

  assign sample    = (settle_q == SW'(SETTLE - 1));
  assign frame_end = sample && (row_idx_q == RW'(ROWS - 1));
  assign row       = ~(ROWS'(1) << row_idx_q);

  always_comb begin
    settle_d  = sample ? '0 : settle_q + SW'(1);
    row_idx_d = row_idx_q;
    if (sample)
      row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
  end

  // Lowest pressed column of the row currently being sampled.
  logic          row_hit;
  logic [CW-1:0] hit_col;
  always_comb begin
    row_hit = 1'b0;
    hit_col = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (!col[c]) begin
        row_hit = 1'b1;
        hit_col = CW'(c);
      end
  end

  // Earlier rows win, so the accumulator only latches the first hit of a frame.
  logic          acc_hit_q;
  logic [KW-1:0] acc_key_q;
  logic          res_hit;
  logic [KW-1:0] res_key;
  assign res_hit = acc_hit_q | row_hit;
  assign res_key = acc_hit_q ? acc_key_q : {row_idx_q, hit_col};

  // ---------------- debounce ----------------
  logic          cand_hit_q, cand_hit_d, stable_hit_q;
  logic [KW-1:0] cand_key_q, cand_key_d, stable_key_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          same, stable_chg;

  always_comb begin
    same       = (res_hit == cand_hit_q) && (!res_hit || (res_key == cand_key_q));
    cand_hit_d = res_hit;
    cand_key_d = res_hit ? res_key : '0;   // "none" always carries key 0
    if (!same)                                  cnt_d = DW'(1);
    else if (cnt_q == DW'(DEBOUNCE_FRAMES))     cnt_d = cnt_q;
    else                                        cnt_d = cnt_q + DW'(1);
    stable_chg = frame_end && (cnt_d == DW'(DEBOUNCE_FRAMES)) &&
                 ((cand_hit_d != stable_hit_q) || (cand_key_d != stable_key_q));
  end

  // ---------------- event generation ----------------
  logic          push_vld, push_rel;
  logic [KW-1:0] push_key;
`ifdef KEYPAD_RELEASE_EVT_EN
  // K -> J queues release(K) now and press(J) on the following clock.
  logic          pend_q, pend_d;
  logic [KW-1:0] pend_key_q, pend_key_d;
  always_comb begin
    push_vld   = 1'b0;
    push_rel   = 1'b0;
    push_key   = '0;
    pend_d     = 1'b0;
    pend_key_d = pend_key_q;
    if (pend_q) begin
      push_vld = 1'b1;
      push_key = pend_key_q;
    end
    if (stable_chg) begin
      push_vld = 1'b1;
      if (stable_hit_q) begin
        push_rel = 1'b1;
        push_key = stable_key_q;
        if (cand_hit_d) begin
          pend_d     = 1'b1;
          pend_key_d = cand_key_d;
        end
      end else begin
        push_key = cand_key_d;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_q     <= 1'b0;
      pend_key_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_key_q <= pend_key_d;
    end
`else
  always_comb begin
    push_vld = stable_chg && cand_hit_d;
    push_rel = 1'b0;
    push_key = cand_key_d;
  end
`endif

  // ---------------- FWFT event FIFO ----------------
  logic [KW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          empty, full, pop, push_ok, drop;
  logic [KW:0]   head;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && evt.evt_ready;
  assign push_ok = push_vld && (!full || pop);
  assign drop    = push_vld && full && !pop;
  assign head    = mem_q[rd_q[AW-1:0]];

  assign evt.evt_valid   = !empty;
  assign evt.evt_key     = empty ? '0 : head[KW-1:0];
  assign evt.evt_release = !empty && head[KW];
  assign key_held        = stable_hit_q;

  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q[AW-1:0]] <= {push_rel, push_key};

  // ---------------- state registers ----------------
  logic overflow_q, overflow_d;
  assign overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
  assign overflow   = overflow_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      settle_q     <= '0;
      row_idx_q    <= '0;
      acc_hit_q    <= 1'b0;
      acc_key_q    <= '0;
      cand_hit_q   <= 1'b0;
      cand_key_q   <= '0;
      cnt_q        <= '0;
      stable_hit_q <= 1'b0;
      stable_key_q <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      overflow_q   <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      row_idx_q  <= row_idx_d;
      overflow_q <= overflow_d;
      if (sample) begin
        if (frame_end) begin
          acc_hit_q  <= 1'b0;
          acc_key_q  <= '0;
          cand_hit_q <= cand_hit_d;
          cand_key_q <= cand_key_d;
          cnt_q      <= cnt_d;
        end else if (!acc_hit_q && row_hit) begin
          acc_hit_q <= 1'b1;
          acc_key_q <= {row_idx_q, hit_col};
        end
      end
      if (stable_chg) begin
        stable_hit_q <= cand_hit_d;
        stable_key_q <= cand_key_d;
      end
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop)     rd_q <= rd_q + (AW+1)'(1);
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed + randomized bench for keypad_matrix_scanner with a frame-level
// reference model (queue of expected events, debounce by per-frame counting).
module tb_keypad_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, SETTLE = 2, DB = 3, DEPTH = 4;
  localparam int FRAME = ROWS * SETTLE;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic overflow_clr = 1'b0;
  logic key_held, overflow;
  logic [COLS-1:0] col;
  logic [ROWS-1:0] row;
  logic [ROWS*COLS-1:0] pressed = '0;

  keypad_matrix_scanner_if #(.KW(4)) evt ();

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE),
    .DEBOUNCE_FRAMES(DB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row), .evt(evt),
    .key_held(key_held), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Physical switch matrix: a pressed switch pulls its column low when its row is driven.
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && pressed[r*COLS+c]) col[c] = 1'b0;
  end

  typedef struct { int key; bit rel; } ev_t;
  ev_t q[$];
  int  cyc, cand, cnt, stable, pend_key;
  bit  ovf, pend_v;
  int  nvec, nerr, obs_pops;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS*COLS-1:0] kb(int r, int c);
    logic [ROWS*COLS-1:0] m;
    m = '0;
    m[r*COLS+c] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    cyc = 0; cand = -1; cnt = 0; stable = -1; ovf = 1'b0; pend_v = 1'b0; pend_key = 0;
  endtask

  task automatic mpush(int k, bit r);
    ev_t e;
    e.key = k;
    e.rel = r;
    if (q.size() < DEPTH) q.push_back(e);
    else ovf = 1'b1;
  endtask

  task automatic m_frame();
    int res;
    res = -1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (res < 0 && pressed[r*COLS+c]) res = r * 4 + c;
    if (res == cand) begin
      if (cnt < DB) cnt++;
    end else begin
      cand = res;
      cnt  = 1;
    end
    if (cnt == DB && cand != stable) begin
      if (REL && stable >= 0) begin
        mpush(stable, 1'b1);
        if (cand >= 0) begin pend_v = 1'b1; pend_key = cand; end
      end else if (cand >= 0) begin
        mpush(cand, 1'b0);
      end
      stable = cand;
    end
  endtask

  task automatic check_outputs();
    logic [ROWS-1:0] exp_row;
    exp_row = ~(ROWS'(1) << ((cyc / SETTLE) % ROWS));
    chk("row", row, exp_row);
    chk("evt_valid", evt.evt_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("evt_key", evt.evt_key, q[0].key);
      chk("evt_release", evt.evt_release, q[0].rel);
    end
    chk("key_held", key_held, stable >= 0);
    chk("overflow", overflow, ovf);
  endtask

  task automatic tick();
    bit pop;
    pop = (q.size() != 0) && evt.evt_ready;
    if (evt.evt_valid && evt.evt_ready) obs_pops++;
    @(posedge clk);
    if (pop) q.delete(0);
    if (overflow_clr) ovf = 1'b0;
    if (pend_v) begin pend_v = 1'b0; mpush(pend_key, 1'b0); end
    if (cyc % FRAME == FRAME - 1) m_frame();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic run_frames(logic [ROWS*COLS-1:0] m, int n, bit rnd);
    pressed = m;
    repeat (n * FRAME) begin
      if (rnd) begin
        evt.evt_ready = ($urandom % 4) != 0;
        overflow_clr  = ($urandom % 16) == 0;
      end
      tick();
    end
  endtask

  initial begin
    int bp_keys [5];
    logic [ROWS*COLS-1:0] m;
    bp_keys = '{1, 6, 11, 14, 3};
    nvec = 0; nerr = 0; obs_pops = 0;
    evt.evt_ready = 1'b1;
    model_reset();

    // reset state
    #12;
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", evt.evt_valid, 1'b0);
    chk("rst_key", evt.evt_key, 4'h0);
    chk("rst_release", evt.evt_release, 1'b0);
    chk("rst_key_held", key_held, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;

    // single press (2,1) -> key 9
    obs_pops = 0;
    run_frames(kb(2, 1), 5, 1'b0);
    chk("single_press_count", obs_pops, 1);
    chk("single_key_held", key_held, 1'b1);
    run_frames('0, 4, 1'b0);
    chk("single_total_count", obs_pops, 1 + int'(REL));

    // bounce rejection on (1,3)
    obs_pops = 0;
    for (int f = 0; f < 6; f++) run_frames((f % 2 == 0) ? kb(1, 3) : '0, 1, 1'b0);
    run_frames('0, 3, 1'b0);
    chk("bounce_count", obs_pops, 0);
    chk("bounce_key_held", key_held, 1'b0);

    // press / release of (0,0)
    obs_pops = 0;
    run_frames(kb(0, 0), 4, 1'b0);
    run_frames('0, 4, 1'b0);
    chk("release_count", obs_pops, 1 + int'(REL));
    chk("release_key_held", key_held, 1'b0);

    // priority: (1,0) beats (3,2)
    obs_pops = 0;
    run_frames(kb(3, 2) | kb(1, 0), 5, 1'b0);
    chk("prio_count", obs_pops, 1);
    run_frames('0, 4, 1'b0);

    // backpressure and overflow
    evt.evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frames(kb(bp_keys[i] / 4, bp_keys[i] % 4), 3, 1'b0);
      run_frames('0, 3, 1'b0);
    end
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_valid", evt.evt_valid, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("bp_overflow_clr", overflow, 1'b0);
    evt.evt_ready = 1'b1;
    obs_pops = 0;
    run_frames('0, 2, 1'b0);
    chk("bp_drain_count", obs_pops, 4);

    // randomized key runs with random backpressure
    for (int i = 0; i < 14; i++) begin
      int sel;
      sel = int'($urandom % 4);
      m = '0;
      if (sel != 0) m[$urandom % 16] = 1'b1;
      if (sel == 3) m[$urandom % 16] = 1'b1;
      run_frames(m, int'($urandom_range(1, 5)), 1'b1);
    end
    overflow_clr = 1'b0;
    evt.evt_ready = 1'b1;
    run_frames('0, 4, 1'b0);

    // reset mid-operation while events are queued and row 2 is driven
    evt.evt_ready = 1'b0;
    run_frames(kb(0, 2), 3, 1'b0);
    run_frames('0, 3, 1'b0);
    run_frames(kb(2, 3), 3, 1'b0);
    repeat (4) tick();
    chk("mid_row2", row, 4'b1011);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", evt.evt_valid, 1'b0);
    chk("mid_rst_row", row, 4'b1110);
    chk("mid_rst_key_held", key_held, 1'b0);
    model_reset();
    pressed = '0;
    evt.evt_ready = 1'b1;
    #2;
    reset_n = 1'b1;
    obs_pops = 0;
    run_frames('0, 4, 1'b0);
    chk("mid_no_stale", obs_pops, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
